// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-stage definitions: bus widths, ROM enable encoding and queue sizing.
package inst_fetch_queue_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int InstQDepth     = 2;
    localparam int InstQDepthLog2 = 1;

endpackage : inst_fetch_queue_pkg

// File: rtl/inst_fetch_queue_queue.sv
// Small synchronous FIFO of {pc, inst} pairs with flush; head outputs come from registers only.
module inst_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = InstQDepth,
    parameter int PTR_W  = InstQDepthLog2,
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0] push_inst,
    output logic [PTR_W:0]    count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0] head_inst
);

    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointer and occupancy bookkeeping; a flush empties the queue regardless of push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; when full, a push lands in the slot being popped on the same edge.
    // NOTE: payload registers carry no reset -- count gates every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = head_valid ? pc_mem[rd_ptr]   : '0;
    assign head_inst  = head_valid ? inst_mem[rd_ptr] : INST_W'(ZeroWord);

endmodule : inst_queue

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the pc and ROM enable, captures each ROM word into a queue for decode.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = InstAddrBus,
    parameter int                INST_W   = InstBus,
    parameter int                QDEPTH   = InstQDepth,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  q_count;
    logic              push;
    logic              pop;
    logic              target_unused;

    // Redirect targets are always word aligned, so the two low bits are dropped on purpose.
    assign target_unused = ^branch_target_i[1:0];

    assign pop  = id_valid_o & id_ready_i;
    assign push = (rom_ce_o == ChipEnable) & ~branch_flag_i
                & ((q_count < CNT_W'(QDEPTH)) | pop);

    assign rom_addr_o = pc;

    // ROM enable comes up one edge after reset release and then stays on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rom_ce_o <= ChipDisable;
        else      rom_ce_o <= ChipEnable;
    end

    // The pc moves on a redirect or a successful fetch; otherwise the ROM address is held stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (branch_flag_i) begin
            pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + ADDR_W'(4);
        end
    end

    inst_queue #(
        .DEPTH  (QDEPTH),
        .PTR_W  (PTR_W),
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (branch_flag_i),
        .push_pc    (pc),
        .push_inst  (rom_inst_i),
        .count      (q_count),
        .head_valid (id_valid_o),
        .head_pc    (id_pc_o),
        .head_inst  (id_inst_o)
    );

endmodule : inst_fetch_queue

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: hand-computed vector table plus a cycle-level scoreboard model.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;
    } vec_t;

    // Scoreboard model state
    entry_t      mq[$];
    logic [31:0] m_pc;
    logic        m_ce;

    vec_t vecs[15];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    assign rom_inst = rom_word(rom_addr);

    inst_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .rom_inst_i      (rom_inst),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .id_valid_o      (id_valid),
        .id_ready_i      (id_ready),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0;
        m_ce = 1'b0;
    endtask

    task automatic model_check(input string tag);
        check({tag, " rom_ce"},   {31'b0, rom_ce},   {31'b0, m_ce});
        check({tag, " rom_addr"}, rom_addr,          m_pc);
        check({tag, " valid"},    {31'b0, id_valid}, {31'b0, (mq.size() != 0)});
        check({tag, " pc"},       id_pc,             (mq.size() != 0) ? mq[0].pc   : 32'h0);
        check({tag, " inst"},     id_inst,           (mq.size() != 0) ? mq[0].inst : 32'h0);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt, input string tag);
        logic m_pop;
        logic m_push;
        id_ready      = rdy;
        branch_flag   = br;
        branch_target = tgt;
        m_pop  = (mq.size() != 0) && rdy;
        m_push = m_ce && !br && ((mq.size() < 2) || m_pop);
        @(posedge clk);
        if (br) begin
            mq.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
        @(negedge clk);
        model_check(tag);
    endtask

    initial begin
        // rdy br tgt | valid pc inst addr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,   32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  32'h100, 32'h4};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h101, 32'h8};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'h102, 32'hC};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h102, 32'h10};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h102, 32'h10};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h102, 32'h10};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h102, 32'h10};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h102, 32'h10};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  32'h103, 32'h14};
        vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'h104, 32'h18};
        vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 32'h105, 32'h1C};
        vecs[12] = '{1'b1, 1'b1, 32'h43, 1'b0, 32'h0,  32'h0,   32'h40};
        vecs[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h110, 32'h44};
        vecs[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 32'h111, 32'h48};

        // Reset state before any edge
        rst           = 1'b0;
        id_ready      = 1'b1;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        model_reset();
        #2;
        model_check("reset");
        @(negedge clk);
        rst = 1'b1;

        // Table: start-up, stall with full queue, pop+push when full, redirect with simultaneous pop
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].rdy, vecs[i].br, vecs[i].tgt, $sformatf("vec%0d model", i));
            check($sformatf("vec%0d valid", i), {31'b0, id_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d pc", i),    id_pc,    vecs[i].exp_pc);
            check($sformatf("vec%0d inst", i),  id_inst,  vecs[i].exp_inst);
            check($sformatf("vec%0d addr", i),  rom_addr, vecs[i].exp_addr);
        end

        // Fill the queue, then assert reset between edges: outputs must clear immediately
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, "fill");
        check("full before reset", {31'b0, id_valid}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async rst valid",  {31'b0, id_valid}, 32'h0);
        check("async rst ce",     {31'b0, rom_ce},   32'h0);
        check("async rst addr",   rom_addr,          32'h0);
        check("async rst inst",   id_inst,           32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Restart with decode stalled: exactly two entries, address parked at 0x8
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, "stall");
        check("stall addr", rom_addr, 32'h8);
        check("stall head", id_pc,    32'h0);
        cycle(1'b1, 1'b0, 32'h0, "drain1");
        check("drain1 head", id_pc, 32'h4);
        cycle(1'b1, 1'b0, 32'h0, "drain2");
        check("drain2 head", id_pc, 32'h8);

        // Address wrap at the top of the space; target low bits forced to zero
        cycle(1'b1, 1'b1, 32'hFFFF_FFFE, "wrap br");
        check("wrap br addr", rom_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0, "wrap fetch");
        check("wrap next addr", rom_addr, 32'h0);
        check("wrap head pc",   id_pc,    32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0, "wrap after");
        check("wrap head 0", id_pc, 32'h0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom,
                  $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_queue
